gate_actuator: RTL and testbench



---
 rtl/gate_pkg.sv | 33 +++
 rtl/gate_travel_timer.sv | 34 +++
 rtl/gate_actuator.sv | 189 ++++++++++++++++++
 tb/tb_gate_actuator.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gate_pkg.sv
// Shared definitions for the parking-barrier actuator: state encoding,
// fault codes and the cycle-counter ceiling.
package gate_pkg;

  typedef enum logic [3:0] {
    ST_INIT,
    ST_HOMING,
    ST_CLOSED,
    ST_OPENING,
    ST_SETTLE_UP,
    ST_OPEN,
    ST_CLOSING,
    ST_REVERSE,
    ST_FAULT
  } gate_state_t;

  localparam logic [1:0] FLT_NONE    = 2'b00;
  localparam logic [1:0] FLT_TIMEOUT = 2'b01;
  localparam logic [1:0] FLT_SENSOR  = 2'b10;

  localparam logic [7:0] CYCLE_SAT = 8'd255;

  // States in which the motor runs and the travel timeout applies.
  function automatic logic is_travel(input gate_state_t s);
    return (s == ST_HOMING) || (s == ST_OPENING) || (s == ST_CLOSING);
  endfunction

  // Motors-off dwell states that reuse the timer to count SETTLE cycles.
  function automatic logic is_dwell(input gate_state_t s);
    return (s == ST_SETTLE_UP) || (s == ST_REVERSE);
  endfunction

endpackage

// File: rtl/gate_travel_timer.sv
// Loadable up-counter with clear and enable; term_o flags when the count
// equals TERMINAL. Updates on the falling clock edge like the rest of the actuator.
module gate_travel_timer #(
  parameter int WIDTH    = 5,
  parameter int TERMINAL = 15
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  input  logic             en_i,
  output logic             term_o
);

  localparam logic [WIDTH-1:0] TERM_V = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] r_count;

  always_ff @(negedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (clear_i) begin
      r_count <= '0;
    end else if (load_i) begin
      r_count <= load_val_i;
    end else if (en_i) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign term_o = (r_count == TERM_V);

endmodule

// File: rtl/gate_actuator.sv
// Motor-side barrier driver: turns open/close pulses into bounded motor runs
// between limit switches, with dead-time, obstacle reversal and fault latching.
module gate_actuator
  import gate_pkg::*;
#(
  parameter int TRAVEL_MAX = 16,
  parameter int SETTLE     = 2
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       open_i,
  input  logic       close_i,
  input  logic       lim_up_i,
  input  logic       lim_down_i,
  input  logic       obstacle_i,
  input  logic       fault_ack_i,
  output logic       motor_up_o,
  output logic       motor_down_o,
  output logic       gate_up_o,
  output logic       gate_down_o,
  output logic       fault_o,
  output logic [1:0] fault_code_o,
  output logic [7:0] cycle_count_o
);

  localparam int TW = $clog2(TRAVEL_MAX + 1);
  // Dwells preload so that the shared terminal (TRAVEL_MAX-1) is hit after
  // exactly SETTLE cycles; requires SETTLE <= TRAVEL_MAX.
  localparam logic [TW-1:0] DWELL_LOAD = TW'(TRAVEL_MAX - SETTLE);

  gate_state_t r_state;
  gate_state_t w_state_next;
  logic        r_close_pend;
  logic        w_close_pend_next;
  logic [1:0]  r_fault_code;
  logic [1:0]  w_fault_code_next;
  logic [7:0]  r_cycle_count;
  logic        w_count_inc;
  logic        r_motor_up;
  logic        r_motor_down;
  logic        r_gate_up;
  logic        r_gate_down;
  logic        r_fault;
  logic        w_term;
  logic        w_entering;
  logic        w_timer_clear;
  logic        w_timer_load;
  logic        w_timer_en;

  gate_travel_timer #(
    .WIDTH    (TW),
    .TERMINAL (TRAVEL_MAX - 1)
  ) u_timer (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .clear_i    (w_timer_clear),
    .load_i     (w_timer_load),
    .load_val_i (DWELL_LOAD),
    .en_i       (w_timer_en),
    .term_o     (w_term)
  );

  always_comb begin
    w_state_next      = r_state;
    w_close_pend_next = r_close_pend;
    w_fault_code_next = r_fault_code;
    w_count_inc       = 1'b0;

    case (r_state)
      ST_INIT: w_state_next = ST_HOMING;

      ST_HOMING: begin
        if (lim_down_i) begin
          w_state_next = ST_CLOSED;
        end else if (w_term) begin
          w_state_next      = ST_FAULT;
          w_fault_code_next = FLT_TIMEOUT;
        end
      end

      ST_CLOSED: begin
        if (open_i) w_state_next = ST_OPENING;
      end

      ST_OPENING: begin
        if (close_i) w_close_pend_next = 1'b1;
        if (lim_up_i) begin
          w_state_next = ST_SETTLE_UP;
        end else if (w_term) begin
          w_state_next      = ST_FAULT;
          w_fault_code_next = FLT_TIMEOUT;
        end
      end

      ST_SETTLE_UP: begin
        if (w_term) begin
          if (r_close_pend) begin
            w_state_next      = ST_CLOSING;
            w_close_pend_next = 1'b0;
          end else begin
            w_state_next = ST_OPEN;
          end
        end
      end

      ST_OPEN: begin
        if (close_i) w_state_next = ST_CLOSING;
      end

      ST_CLOSING: begin
        if (lim_down_i) begin
          w_state_next = ST_CLOSED;
          w_count_inc  = 1'b1;
        end else if (obstacle_i || open_i) begin
          w_state_next = ST_REVERSE;
        end else if (w_term) begin
          w_state_next      = ST_FAULT;
          w_fault_code_next = FLT_TIMEOUT;
        end
      end

      ST_REVERSE: begin
        if (w_term) w_state_next = ST_OPENING;
      end

      ST_FAULT: begin
        if (fault_ack_i) begin
          w_state_next      = ST_HOMING;
          w_fault_code_next = FLT_NONE;
        end
      end

      default: w_state_next = ST_INIT;
    endcase

    // Both limits at once means a broken switch: overrides everything else.
    if (r_state != ST_INIT && r_state != ST_FAULT && lim_up_i && lim_down_i) begin
      w_state_next      = ST_FAULT;
      w_fault_code_next = FLT_SENSOR;
      w_count_inc       = 1'b0;
    end

    // A close request queued before a fault must not survive the re-home.
    if (w_state_next == ST_FAULT && r_state != ST_FAULT) begin
      w_close_pend_next = 1'b0;
    end
  end

  assign w_entering    = (w_state_next != r_state);
  assign w_timer_clear = w_entering && is_travel(w_state_next);
  assign w_timer_load  = w_entering && is_dwell(w_state_next);
  assign w_timer_en    = !w_entering && (is_travel(r_state) || is_dwell(r_state));

  always_ff @(negedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state       <= ST_INIT;
      r_close_pend  <= 1'b0;
      r_fault_code  <= FLT_NONE;
      r_cycle_count <= '0;
      r_motor_up    <= 1'b0;
      r_motor_down  <= 1'b0;
      r_gate_up     <= 1'b0;
      r_gate_down   <= 1'b0;
      r_fault       <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_close_pend <= w_close_pend_next;
      r_fault_code <= w_fault_code_next;
      if (w_count_inc && r_cycle_count != CYCLE_SAT) begin
        r_cycle_count <= r_cycle_count + 8'd1;
      end
      // Outputs are registered decodes of the state being entered.
      r_motor_up   <= (w_state_next == ST_OPENING);
      r_motor_down <= (w_state_next == ST_HOMING) || (w_state_next == ST_CLOSING);
      r_gate_up    <= (w_state_next == ST_OPEN);
      r_gate_down  <= (w_state_next == ST_CLOSED);
      r_fault      <= (w_state_next == ST_FAULT);
    end
  end

  assign motor_up_o    = r_motor_up;
  assign motor_down_o  = r_motor_down;
  assign gate_up_o     = r_gate_up;
  assign gate_down_o   = r_gate_down;
  assign fault_o       = r_fault;
  assign fault_code_o  = r_fault_code;
  assign cycle_count_o = r_cycle_count;

endmodule

// File: tb/tb_gate_actuator.sv
// Directed bench for gate_actuator: homing, normal cycle, reversal, timeout,
// sensor conflict, pending close, command priorities and counter saturation.
module tb_gate_actuator;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       open_i;
  logic       close_i;
  logic       lim_up_i;
  logic       lim_down_i;
  logic       obstacle_i;
  logic       fault_ack_i;
  logic       motor_up_o;
  logic       motor_down_o;
  logic       gate_up_o;
  logic       gate_down_o;
  logic       fault_o;
  logic [1:0] fault_code_o;
  logic [7:0] cycle_count_o;

  int n_vec = 0;
  int n_err = 0;
  int n_up;

  // Output vector {motor_up, motor_down, gate_up, gate_down, fault}
  localparam logic [4:0] O_NONE = 5'b00000;
  localparam logic [4:0] O_UP   = 5'b10000;
  localparam logic [4:0] O_DN   = 5'b01000;
  localparam logic [4:0] O_GU   = 5'b00100;
  localparam logic [4:0] O_GD   = 5'b00010;
  localparam logic [4:0] O_F    = 5'b00001;

  logic [4:0] outs;
  assign outs = {motor_up_o, motor_down_o, gate_up_o, gate_down_o, fault_o};

  always #5 clk_i = ~clk_i;

  gate_actuator #(.TRAVEL_MAX(16), .SETTLE(2)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .open_i        (open_i),
    .close_i       (close_i),
    .lim_up_i      (lim_up_i),
    .lim_down_i    (lim_down_i),
    .obstacle_i    (obstacle_i),
    .fault_ack_i   (fault_ack_i),
    .motor_up_o    (motor_up_o),
    .motor_down_o  (motor_down_o),
    .gate_up_o     (gate_up_o),
    .gate_down_o   (gate_down_o),
    .fault_o       (fault_o),
    .fault_code_o  (fault_code_o),
    .cycle_count_o (cycle_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("  ok %s = %0h", tag, got);
    end
  endtask

  task automatic chk_out(input string tag, input logic [4:0] exp);
    chk(tag, {27'd0, outs}, {27'd0, exp});
  endtask

  // One falling-edge state update; inputs are driven and outputs sampled
  // just after the rising edge.
  task automatic step();
    @(negedge clk_i);
    @(posedge clk_i);
    #1;
  endtask

  // From CLOSED: open, travel n cycles, hit the upper limit, settle into OPEN.
  task automatic run_open(input int n);
    lim_down_i = 1'b0;
    open_i = 1'b1;
    step();
    open_i = 1'b0;
    repeat (n - 1) step();
    lim_up_i = 1'b1;
    repeat (3) step();
  endtask

  // From OPEN: close, travel n cycles, hit the lower limit into CLOSED.
  task automatic run_close(input int n);
    lim_up_i = 1'b0;
    close_i = 1'b1;
    step();
    close_i = 1'b0;
    repeat (n - 1) step();
    lim_down_i = 1'b1;
    step();
  endtask

  initial begin
    reset_i = 1'b1;
    open_i = 1'b0;
    close_i = 1'b0;
    lim_up_i = 1'b0;
    lim_down_i = 1'b1;
    obstacle_i = 1'b0;
    fault_ack_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    chk_out("reset_outs", O_NONE);
    chk("reset_code", {30'd0, fault_code_o}, 32'd0);
    chk("reset_count", {24'd0, cycle_count_o}, 32'd0);

    // Homing
    reset_i = 1'b0;
    chk_out("init", O_NONE);
    step();
    chk_out("homing", O_DN);
    step();
    chk_out("closed", O_GD);
    chk("count_after_home", {24'd0, cycle_count_o}, 32'd0);

    // Normal cycle
    lim_down_i = 1'b0;
    open_i = 1'b1;
    step();
    open_i = 1'b0;
    chk_out("opening", O_UP);
    repeat (4) begin
      step();
      chk_out("opening_run", O_UP);
    end
    lim_up_i = 1'b1;
    step();
    chk_out("settle1", O_NONE);
    step();
    chk_out("settle2", O_NONE);
    step();
    chk_out("open", O_GU);
    open_i = 1'b1;
    step();
    open_i = 1'b0;
    chk_out("open_ignores_open", O_GU);
    lim_up_i = 1'b0;
    close_i = 1'b1;
    step();
    close_i = 1'b0;
    chk_out("closing", O_DN);
    step();
    lim_down_i = 1'b1;
    step();
    chk_out("closed_again", O_GD);
    chk("count_1", {24'd0, cycle_count_o}, 32'd1);

    // Obstacle reversal
    run_open(3);
    lim_up_i = 1'b0;
    close_i = 1'b1;
    step();
    close_i = 1'b0;
    step();
    chk_out("closing_obs", O_DN);
    obstacle_i = 1'b1;
    step();
    obstacle_i = 1'b0;
    chk_out("reverse1", O_NONE);
    step();
    chk_out("reverse2", O_NONE);
    step();
    chk_out("reopening", O_UP);
    lim_up_i = 1'b1;
    repeat (3) step();
    chk_out("reopened", O_GU);
    run_close(2);
    chk("count_2", {24'd0, cycle_count_o}, 32'd2);

    // Opening timeout
    lim_down_i = 1'b0;
    open_i = 1'b1;
    step();
    open_i = 1'b0;
    n_up = 0;
    for (int i = 0; i < 40 && motor_up_o; i++) begin
      n_up++;
      step();
    end
    chk("timeout_motor_cycles", n_up, 32'd16);
    chk_out("timeout_fault", O_F);
    chk("timeout_code", {30'd0, fault_code_o}, 32'd1);
    fault_ack_i = 1'b1;
    step();
    fault_ack_i = 1'b0;
    chk_out("ack_homing", O_DN);
    chk("ack_code", {30'd0, fault_code_o}, 32'd0);
    lim_down_i = 1'b1;
    step();
    chk_out("rehomed", O_GD);

    // Sensor conflict while OPEN
    run_open(2);
    lim_down_i = 1'b1;
    step();
    chk_out("conflict", O_F);
    chk("conflict_code", {30'd0, fault_code_o}, 32'd2);
    repeat (2) step();
    chk_out("conflict_hold", O_F);
    lim_up_i = 1'b0;
    fault_ack_i = 1'b1;
    step();
    fault_ack_i = 1'b0;
    chk_out("conflict_ack", O_DN);
    chk("conflict_ack_code", {30'd0, fault_code_o}, 32'd0);
    step();
    chk_out("conflict_rehomed", O_GD);

    // Close requested during OPENING skips OPEN
    lim_down_i = 1'b0;
    open_i = 1'b1;
    step();
    open_i = 1'b0;
    close_i = 1'b1;
    step();
    close_i = 1'b0;
    step();
    lim_up_i = 1'b1;
    step();
    chk_out("pend_settle1", O_NONE);
    step();
    chk_out("pend_settle2", O_NONE);
    step();
    chk_out("pend_closing", O_DN);
    lim_up_i = 1'b0;
    step();
    lim_down_i = 1'b1;
    step();
    chk_out("pend_closed", O_GD);
    chk("count_3", {24'd0, cycle_count_o}, 32'd3);

    // Command priorities
    close_i = 1'b1;
    step();
    close_i = 1'b0;
    chk_out("closed_ignores_close", O_GD);
    lim_down_i = 1'b0;
    open_i = 1'b1;
    close_i = 1'b1;
    step();
    open_i = 1'b0;
    close_i = 1'b0;
    chk_out("open_wins", O_UP);
    step();
    lim_up_i = 1'b1;
    repeat (3) step();
    chk_out("open_wins_settled", O_GU);
    lim_up_i = 1'b0;
    open_i = 1'b1;
    close_i = 1'b1;
    step();
    open_i = 1'b0;
    close_i = 1'b0;
    chk_out("close_wins", O_DN);
    lim_down_i = 1'b1;
    obstacle_i = 1'b1;
    step();
    obstacle_i = 1'b0;
    chk_out("limit_beats_obstacle", O_GD);
    chk("count_4", {24'd0, cycle_count_o}, 32'd4);

    // Counter saturation
    repeat (256) begin
      run_open(1);
      run_close(1);
    end
    chk("count_saturated", {24'd0, cycle_count_o}, 32'd255);
    chk_out("sat_closed", O_GD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
